// File: rtl/contador_secuenciador_if.sv
// Bus between the sequencing controller, the front panel / prescaler and the
// four BCD digit counters.
// Command signals (tick, start, stop, clear) are single-cycle pulses sampled on
// the rising clk edge with no back-pressure. ena_k/rst_k are combinational and
// act on the counters at that same edge.
interface contador_secuenciador_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] Qdata3;
  logic [3:0] Qdata2;
  logic [3:0] Qdata1;
  logic [3:0] Qdata0;
  logic       ena3;
  logic       ena2;
  logic       ena1;
  logic       ena0;
  logic       rst3;
  logic       rst2;
  logic       rst1;
  logic       rst0;
  logic       running;
  logic       done;
  logic       wrap;
  logic       fault;
  logic [1:0] dbg_state;

  // Environment side: drives the commands and the digit read-back
  modport master (
    output tick, start, stop, clear, Qdata3, Qdata2, Qdata1, Qdata0,
    input  ena3, ena2, ena1, ena0, rst3, rst2, rst1, rst0,
    input  running, done, wrap, fault, dbg_state
  );

  // Controller side
  modport slave (
    input  tick, start, stop, clear, Qdata3, Qdata2, Qdata1, Qdata0,
    output ena3, ena2, ena1, ena0, rst3, rst2, rst1, rst0,
    output running, done, wrap, fault, dbg_state
  );
endinterface

// File: rtl/contador_secuenciador.sv
// Sequencing controller for a four-digit BCD counter chain: run control,
// per-digit enables and clears, terminal-count detection and illegal-digit
// detection. Digit 3 is the most significant.
module contador_secuenciador #(
  parameter logic [3:0] TC3       = 4'd9,
  parameter logic [3:0] TC2       = 4'd6,
  parameter logic [3:0] TC1       = 4'd7,
  parameter logic [3:0] TC0       = 4'd5,
  parameter int         AUTO_WRAP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  contador_secuenciador_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic WRAP_EN = (AUTO_WRAP != 0);

  state_t state_q, state_d;
  logic   fault_q, fault_d;
  logic   running_q, done_q;

  logic       in_run;
  logic       at_tc;
  logic       illegal;
  logic       adv;
  logic       wrap_hit;
  logic       restart;
  logic       fault_hit;
  logic       clr_all;
  logic [3:0] ena;
  logic [3:0] nine;

  assign in_run  = (state_q == RUN);
  assign at_tc   = ({bus.Qdata3, bus.Qdata2, bus.Qdata1, bus.Qdata0} ==
                    {TC3, TC2, TC1, TC0});
  assign illegal = (bus.Qdata3 > 4'd9) | (bus.Qdata2 > 4'd9) |
                   (bus.Qdata1 > 4'd9) | (bus.Qdata0 > 4'd9);
  assign nine    = {bus.Qdata3 == 4'd9, bus.Qdata2 == 4'd9,
                    bus.Qdata1 == 4'd9, bus.Qdata0 == 4'd9};

  // A tick advances the chain only in RUN, below terminal count, and only when
  // no higher-priority command (clear, stop) claims the cycle.
  assign adv       = in_run & bus.tick & ~at_tc & ~bus.clear & ~bus.stop;
  assign wrap_hit  = WRAP_EN & in_run & bus.tick & at_tc & ~bus.clear & ~bus.stop;
  assign restart   = (state_q == DONE) & bus.start & ~bus.clear & ~bus.stop;
  assign fault_hit = in_run & illegal & ~bus.clear;
  // rst is folded in so the digits see a clear the moment reset rises
  assign clr_all   = rst | bus.clear | restart | wrap_hit | fault_hit;

  // Ripple the carry: a digit counts when every lower digit is at 9
  assign ena[0] = adv;
  assign ena[1] = ena[0] & nine[0];
  assign ena[2] = ena[1] & nine[1];
  assign ena[3] = ena[2] & nine[2];

  assign bus.ena0 = ena[0];
  assign bus.ena1 = ena[1];
  assign bus.ena2 = ena[2];
  assign bus.ena3 = ena[3];

  // A digit at 9 that is enabled wraps to 0 on the same edge
  assign bus.rst0 = clr_all | (ena[0] & nine[0]);
  assign bus.rst1 = clr_all | (ena[1] & nine[1]);
  assign bus.rst2 = clr_all | (ena[2] & nine[2]);
  assign bus.rst3 = clr_all | (ena[3] & nine[3]);

  assign bus.wrap      = wrap_hit;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.dbg_state = state_q;

  // Next-state and sticky fault, command priority clear > stop > start > tick
  always_comb begin
    state_d = state_q;
    fault_d = fault_q | fault_hit;
    if (bus.clear) begin
      state_d = IDLE;
      fault_d = 1'b0;
    end else if (bus.stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (bus.start && (state_q != RUN)) begin
      state_d = RUN;
    end else if (in_run && bus.tick && at_tc && !WRAP_EN) begin
      state_d = DONE;
    end
  end

  // Controller state with registered status decodes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fault_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

endmodule

// File: doc/contador_secuenciador.md
Name: contador_secuenciador

Overview:
- Sequencing controller for the four-digit BCD counter chain built from 4-bit digit counters (digit 3 = MSD, digit 0 = LSD).
- Generates the per-digit enables and synchronous clears, detects the programmable terminal count (default 9675), and implements start/stop/clear run control.
- Reads the four digit values back and checks them for illegal codes.
- Sits between the front-panel control pulses / prescaler tick and the four digit counters.

Parameters:
- TC3, 9, terminal-count digit 3
- TC2, 6, terminal-count digit 2
- TC1, 7, terminal-count digit 1
- TC0, 5, terminal-count digit 0
- AUTO_WRAP, 0, 1 = wrap to 0000 at terminal count and keep running; 0 = halt in DONE

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle count-advance request (from prescaler)
- start  in  1  single-cycle start/resume pulse
- stop  in  1  single-cycle pause pulse
- clear  in  1  single-cycle clear pulse
- Qdata3, Qdata2, Qdata1, Qdata0  in  4 each  digit values fed back from the counters
- ena3, ena2, ena1, ena0  out  1 each  digit count enables
- rst3, rst2, rst1, rst0  out  1 each  digit synchronous clears
- running  out  1  state == RUN
- done  out  1  state == DONE
- wrap  out  1  one-cycle pulse when the chain wraps at terminal count (AUTO_WRAP=1)
- fault  out  1  sticky illegal-digit flag

Behaviour:
- Digit counter contract: on a clk edge, rst_k has priority over ena_k and loads 0; otherwise ena_k increments.
- State encoding is 2 bits: IDLE, RUN, PAUSE, DONE.
- Reset:
  - While rst is high: state = IDLE, fault = 0, all ena_k = 0, all rst_k = 1.
  - running, done and wrap are 0 throughout reset.
- Command priority per cycle: clear > stop > start > tick.
- clear (any state):
  - All rst_k = 1 that cycle; all ena_k = 0.
  - Next state IDLE; fault cleared.
- Transitions:
  - IDLE + start -> RUN.
  - RUN + stop -> PAUSE.
  - PAUSE + start -> RUN.
  - DONE + start -> all rst_k = 1 that cycle, next state RUN (count restarts at 0000).
  - stop in IDLE, PAUSE or DONE is ignored; start in RUN is ignored.
- Enables (combinational from state, tick and registered Qdata), with adv = (state==RUN) & tick & ~at_tc & ~clear & ~stop:
  - ena0 = adv
  - ena1 = ena0 & (Qdata0==9)
  - ena2 = ena1 & (Qdata1==9)
  - ena3 = ena2 & (Qdata2==9)
- Digit roll-over: rst_k = ena_k & (Qdata_k==9), which wraps that digit 9 -> 0 on the same edge the next digit increments.
- Terminal count: at_tc = ({Qdata3..0} == {TC3..TC0}).
  - RUN & tick & at_tc, AUTO_WRAP=1: all rst_k = 1, ena_k = 0, wrap = 1 for that cycle, stay in RUN.
  - RUN & tick & at_tc, AUTO_WRAP=0: no enables or clears, next state DONE; the count holds at terminal value.
- Zero latency: a tick in RUN changes the digits on the same clk edge; no tick is dropped or queued.
- Ticks in IDLE, PAUSE and DONE are discarded.
- Fault:
  - If any Qdata_k > 9 while in RUN, fault is set (registered) and all rst_k = 1 that cycle; state stays RUN.
  - fault stays high until clear or rst.
- Reset mid-count: all digits are cleared and the block returns to IDLE regardless of state.
- running and done are registered decodes of state; wrap is combinational and one cycle wide.

Test Plan:
- Assert rst, release, pulse start, apply 9675 ticks -> digits read 9675 and nothing further increments; with AUTO_WRAP=0, tick 9676 -> done=1, running=0, digits hold 9675.
- AUTO_WRAP=1, count to 9675 then one more tick -> wrap=1 for one cycle, digits 0000, running=1.
- Preload chain at 0999, tick -> ena0..ena3 all high that cycle, rst0..rst2 high; result 1000.
- Counting at 0123, pulse stop, apply 10 ticks, pulse start, apply 2 ticks -> 0125. Then assert start and stop in the same cycle -> PAUSE (stop wins).
- Force Qdata1=12 while in RUN -> fault=1 next cycle, all rst_k pulsed; clear -> fault=0, state IDLE, digits 0000.
- Assert rst asynchronously mid-count at 4321 (between edges) -> rst_k high immediately; after release, state IDLE and digits 0000.
